srv_mem_arb: RTL and testbench

Two-port arbiter that shares the single cache-line refill memory between the instruction cache (port 0) and the data cache (port 1). It accepts level-held line requests from both caches and grants them round-robin. For each granted request it issues a single-cycle request to the memory, waits for the memory's response pulse with a watchdog timeout, and returns the registered 128-bit line to the granted requester. It sits between the cache refill controllers and the memory model.

---
 rtl/srv_mem_arb.sv | 120 ++++++++++++
 tb/tb_srv_mem_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srv_mem_arb.sv
// Round-robin arbiter sharing one cache-line refill memory between the I-cache (port 0)
// and the D-cache (port 1), with a watchdog timeout on every memory transaction.
module srv_mem_arb #(
    parameter int AWIDTH  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic [AWIDTH-1:0] addr0_i,
    output logic              rsp0_o,
    input  logic              req1_i,
    input  logic [AWIDTH-1:0] addr1_i,
    output logic              rsp1_o,
    output logic [LINE_W-1:0] data_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    input  logic              mem_rsp_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              busy_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_q, rr_d;
    logic              err_q, err_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    // A lone requester wins outright; rr_q only breaks ties.
                    if (req0_i && req1_i) begin
                        grant_d = rr_q;
                    end else begin
                        grant_d = req1_i;
                    end
                    rr_d    = ~grant_d;
                    addr_d  = grant_d ? addr1_i : addr0_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_i) begin
                    data_d  = mem_data_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign mem_req_o  = (state_q == ISSUE);
    assign mem_addr_o = addr_q;
    assign rsp0_o     = (state_q == RESP) && !grant_q;
    assign rsp1_o     = (state_q == RESP) && grant_q;
    assign data_o     = data_q;
    assign err_o      = (state_q == RESP) && err_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_srv_mem_arb.sv
// Randomized bench for srv_mem_arb: a transaction-timeline model predicts every output per cycle,
// and directed phases pin the latencies, grant order, timeout and reset-abort behaviour.
module tb_srv_mem_arb;

    localparam int AWIDTH  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_i, req1_i;
    logic [AWIDTH-1:0] addr0_i, addr1_i;
    logic              rsp0_o, rsp1_o;
    logic [LINE_W-1:0] data_o;
    logic              err_o;
    logic              mem_req_o;
    logic [AWIDTH-1:0] mem_addr_o;
    logic              mem_rsp_i;
    logic [LINE_W-1:0] mem_data_i;
    logic              busy_o;

    srv_mem_arb #(.AWIDTH(AWIDTH), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0_i), .addr0_i(addr0_i), .rsp0_o(rsp0_o),
        .req1_i(req1_i), .addr1_i(addr1_i), .rsp1_o(rsp1_o),
        .data_o(data_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rsp_i(mem_rsp_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Model of the transaction in flight, as cycle numbers on a timeline.
    bit                txn_on;
    int                t_port, t_issue, t_rsp, t_k;
    logic [AWIDTH-1:0] t_addr;
    logic [LINE_W-1:0] t_data;
    bit                t_err;
    int                prio, free_cyc, holdoff, pend_k;
    logic [AWIDTH-1:0] last_addr;
    logic [LINE_W-1:0] last_data;
    bit                chk_err_zero;

    bit                req_on[2];
    logic [AWIDTH-1:0] req_addr[2];
    int                req_start[2], drop_cyc[2], launches[2];

    int                prob[2];
    bit                fix_addr_en[2];
    logic [AWIDTH-1:0] fix_addr[2];
    int                delay_mode;
    bit                fix_data_en;
    logic [LINE_W-1:0] fix_data;
    int                stray_cyc, stray_pct, rst_cyc, rst_pct;

    int                rsp_cyc[$];
    int                rsp_port[$];
    bit                rsp_err[$];
    logic [LINE_W-1:0] rsp_data[$];
    int                mreq_cyc[$];
    logic [AWIDTH-1:0] mreq_addr[$];

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                               input logic [LINE_W-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    endtask

    task automatic setDefaults();
        for (int p = 0; p < 2; p++) begin
            prob[p]        = 0;
            fix_addr_en[p] = 1'b0;
            fix_addr[p]    = '0;
            launches[p]    = 0;
            req_start[p]   = 0;
        end
        delay_mode  = -2;
        fix_data_en = 1'b0;
        fix_data    = '0;
        stray_cyc   = -1;
        stray_pct   = 0;
        rst_cyc     = -1;
        rst_pct     = 0;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req0_i    = 1'b0;
        req1_i    = 1'b0;
        addr0_i   = '0;
        addr1_i   = '0;
        mem_rsp_i = 1'b0;
        mem_data_i = '0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        cyc          = 0;
        txn_on       = 1'b0;
        prio         = 0;
        free_cyc     = 0;
        holdoff      = 0;
        pend_k       = -1;
        last_addr    = '0;
        last_data    = '0;
        chk_err_zero = 1'b1;
        t_k          = -1;
        for (int p = 0; p < 2; p++) begin
            req_on[p]   = 1'b0;
            req_addr[p] = '0;
            drop_cyc[p] = -1;
        end
        rsp_cyc.delete();
        rsp_port.delete();
        rsp_err.delete();
        rsp_data.delete();
        mreq_cyc.delete();
        mreq_addr.delete();
    endtask

    task automatic applyStimulus(input int ncycles);
        for (int i = 0; i < ncycles; i++) begin
            bit                exp_busy, exp_mreq, exp_r0, exp_r1, rst_now, in_wait;
            logic [AWIDTH-1:0] exp_maddr;
            logic [LINE_W-1:0] exp_data;
            int                d;

            exp_busy  = txn_on && cyc >= t_issue && cyc <= t_rsp;
            exp_mreq  = txn_on && cyc == t_issue;
            exp_r0    = txn_on && cyc == t_rsp && t_port == 0;
            exp_r1    = txn_on && cyc == t_rsp && t_port == 1;
            exp_maddr = (txn_on && cyc >= t_issue) ? t_addr : last_addr;
            exp_data  = (txn_on && cyc >= t_rsp) ? t_data : last_data;
            checkOutput("busy", busy_o, exp_busy);
            checkOutput("mem_req", mem_req_o, exp_mreq);
            checkOutput("rsp0", rsp0_o, exp_r0);
            checkOutput("rsp1", rsp1_o, exp_r1);
            checkOutput("mem_addr", mem_addr_o, exp_maddr);
            checkOutput("data", data_o, exp_data);
            if (exp_r0 || exp_r1) checkOutput("err", err_o, t_err);
            else if (chk_err_zero) checkOutput("err_after_reset", err_o, 1'b0);
            chk_err_zero = 1'b0;

            if (rsp0_o || rsp1_o) begin
                rsp_cyc.push_back(cyc);
                rsp_port.push_back(rsp1_o ? 1 : 0);
                rsp_err.push_back(err_o);
                rsp_data.push_back(data_o);
            end
            if (mem_req_o) begin
                mreq_cyc.push_back(cyc);
                mreq_addr.push_back(mem_addr_o);
            end

            if (txn_on && cyc == t_rsp) begin
                last_addr         = t_addr;
                last_data         = t_data;
                txn_on            = 1'b0;
                free_cyc          = cyc + 1;
                drop_cyc[t_port]  = cyc + 1;
                req_start[t_port] = cyc + 2;
            end

            in_wait = txn_on && cyc > t_issue && cyc < t_rsp;
            rst_now = (cyc == rst_cyc) || (in_wait && $urandom_range(99) < rst_pct);

            // Requesters hold their level until the response, then drop for at least one cycle.
            for (int p = 0; p < 2; p++) begin
                if (cyc == drop_cyc[p] || rst_now) req_on[p] = 1'b0;
                if (!req_on[p] && !rst_now && launches[p] > 0 && cyc >= req_start[p] &&
                    cyc >= holdoff && $urandom_range(99) < prob[p]) begin
                    req_on[p]   = 1'b1;
                    launches[p] = launches[p] - 1;
                    req_addr[p] = fix_addr_en[p] ? fix_addr[p] : AWIDTH'($urandom);
                end
            end

            if (!rst_now && !txn_on && cyc >= free_cyc && (req_on[0] || req_on[1])) begin
                if (req_on[0] && req_on[1]) t_port = prio;
                else t_port = req_on[1] ? 1 : 0;
                prio    = 1 - t_port;
                t_addr  = req_addr[t_port];
                t_issue = cyc + 1;
                if (delay_mode > 0) d = delay_mode;
                else if (delay_mode == 0) d = -1;
                else if (delay_mode == -1 && $urandom_range(19) == 0) d = -1;
                else d = int'($urandom_range(14, 1));
                if (d < 0) begin
                    t_k    = -1;
                    t_rsp  = cyc + TIMEOUT + 2;
                    t_data = '0;
                    t_err  = 1'b1;
                end else begin
                    t_k    = cyc + 1 + d;
                    t_rsp  = t_k + 1;
                    t_data = fix_data_en ? fix_data : {$urandom, $urandom, $urandom, $urandom};
                    t_err  = 1'b0;
                end
                txn_on = 1'b1;
            end

            in_wait    = txn_on && cyc > t_issue && cyc < t_rsp;
            mem_rsp_i  = 1'b0;
            mem_data_i = {$urandom, $urandom, $urandom, $urandom};
            if (txn_on && cyc == t_k) begin
                mem_rsp_i  = 1'b1;
                mem_data_i = t_data;
            end else if (!in_wait && (cyc == pend_k || cyc == stray_cyc ||
                                      $urandom_range(99) < stray_pct)) begin
                mem_rsp_i = 1'b1;
            end

            if (rst_now) begin
                if (txn_on && t_k > cyc) begin
                    holdoff = t_k + 2;
                    pend_k  = t_k;
                end else begin
                    holdoff = cyc + 2;
                    pend_k  = -1;
                end
                txn_on       = 1'b0;
                prio         = 0;
                last_addr    = '0;
                last_data    = '0;
                free_cyc     = cyc + 1;
                chk_err_zero = 1'b1;
            end

            rst     = rst_now;
            req0_i  = req_on[0];
            addr0_i = req_addr[0];
            req1_i  = req_on[1];
            addr1_i = req_addr[1];
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        setDefaults();

        // Single I-cache request with a 10-cycle memory.
        setDefaults();
        prob[0] = 100; launches[0] = 1;
        fix_addr_en[0] = 1'b1; fix_addr[0] = 32'h40;
        delay_mode = 10;
        fix_data_en = 1'b1; fix_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        doReset();
        applyStimulus(16);
        checkOutput("p1_mreq_count", mreq_cyc.size(), 1);
        if (mreq_cyc.size() > 0) begin
            checkOutput("p1_mreq_cycle", mreq_cyc[0], 1);
            checkOutput("p1_mreq_addr", mreq_addr[0], 32'h40);
        end
        checkOutput("p1_rsp_count", rsp_cyc.size(), 1);
        if (rsp_cyc.size() > 0) begin
            checkOutput("p1_rsp_cycle", rsp_cyc[0], 12);
            checkOutput("p1_rsp_port", rsp_port[0], 0);
            checkOutput("p1_rsp_data", rsp_data[0], 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
            checkOutput("p1_rsp_err", rsp_err[0], 1'b0);
        end

        // Simultaneous requests from both ports.
        setDefaults();
        prob[0] = 100; launches[0] = 1; fix_addr_en[0] = 1'b1; fix_addr[0] = 32'h100;
        prob[1] = 100; launches[1] = 1; fix_addr_en[1] = 1'b1; fix_addr[1] = 32'h200;
        delay_mode = 3;
        doReset();
        applyStimulus(30);
        checkOutput("p2_mreq_count", mreq_cyc.size(), 2);
        checkOutput("p2_rsp_count", rsp_cyc.size(), 2);
        if (rsp_cyc.size() > 1 && mreq_cyc.size() > 1) begin
            checkOutput("p2_first_port", rsp_port[0], 0);
            checkOutput("p2_first_rsp_cycle", rsp_cyc[0], 5);
            checkOutput("p2_second_port", rsp_port[1], 1);
            checkOutput("p2_second_mreq_cycle", mreq_cyc[1], 7);
            checkOutput("p2_second_mreq_addr", mreq_addr[1], 32'h200);
            checkOutput("p2_second_rsp_cycle", rsp_cyc[1], 11);
        end

        // Both ports requesting continuously: grants must alternate.
        setDefaults();
        prob[0] = 100; launches[0] = 3;
        prob[1] = 100; launches[1] = 3;
        doReset();
        applyStimulus(150);
        checkOutput("p3_rsp_count", rsp_cyc.size(), 6);
        for (int i = 0; i < rsp_port.size() && i < 6; i++)
            checkOutput("p3_grant_order", rsp_port[i], i % 2);

        // Silent memory: timeout response, then a late memory pulse that must be dropped.
        setDefaults();
        prob[0] = 100; launches[0] = 1;
        delay_mode = 0;
        stray_cyc = TIMEOUT + 7;
        doReset();
        applyStimulus(85);
        checkOutput("p4_rsp_count", rsp_cyc.size(), 1);
        if (rsp_cyc.size() > 0) begin
            checkOutput("p4_rsp_cycle", rsp_cyc[0], TIMEOUT + 2);
            checkOutput("p4_rsp_err", rsp_err[0], 1'b1);
            checkOutput("p4_rsp_data", rsp_data[0], '0);
        end
        checkOutput("p4_idle_at_end", busy_o, 1'b0);

        // Reset in WAIT aborts; priority returns to port 0 afterwards.
        setDefaults();
        prob[0] = 100; launches[0] = 2;
        prob[1] = 100; launches[1] = 1; req_start[1] = 13;
        delay_mode = 10;
        rst_cyc = 5;
        doReset();
        applyStimulus(60);
        checkOutput("p5_rsp_count", rsp_cyc.size(), 2);
        checkOutput("p5_mreq_count", mreq_cyc.size(), 3);
        if (rsp_cyc.size() > 1 && mreq_cyc.size() > 1) begin
            checkOutput("p5_first_port", rsp_port[0], 0);
            checkOutput("p5_first_rsp_cycle", rsp_cyc[0], 25);
            checkOutput("p5_restart_mreq_cycle", mreq_cyc[1], 14);
            checkOutput("p5_second_port", rsp_port[1], 1);
            checkOutput("p5_second_rsp_cycle", rsp_cyc[1], 38);
        end

        // Long random run with stray memory pulses, timeouts and occasional resets.
        setDefaults();
        prob[0] = 25; launches[0] = 30;
        prob[1] = 25; launches[1] = 30;
        delay_mode = -1;
        stray_pct = 5;
        rst_pct = 1;
        doReset();
        applyStimulus(3000);
        checkOutput("p6_made_progress", rsp_cyc.size() > 10, 1'b1);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
